// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
module fifo_wr_arbiter #(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] data0,
    input  logic          req1,
    input  logic [DW-1:0] data1,
    input  logic          fifo_full,
    output logic          fifo_wen,
    output logic [DW-1:0] fifo_din,
    output logic          ack0,
    output logic          ack1,
    output logic          gnt0,
    output logic          gnt1
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign gnt0 = (state_q == G0);
    assign gnt1 = (state_q == G1);

    // Outputs are forced low while rst is high so a mid-burst reset never writes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        fifo_wen = 1'b0;
        fifo_din = '0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) state_d = last_q ? G0 : G1;
                    else if (req0)    state_d = G0;
                    else if (req1)    state_d = G1;
                end
                G0: begin
                    fifo_din = data0;
                    if (req0 && !fifo_full) begin
                        fifo_wen = 1'b1;
                        ack0     = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            last_d  = 1'b0;
                            state_d = req1 ? G1 : G0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (!req0) begin
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        state_d = req1 ? G1 : IDLE;
                    end
                end
                G1: begin
                    fifo_din = data1;
                    if (req1 && !fifo_full) begin
                        fifo_wen = 1'b1;
                        ack1     = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            last_d  = 1'b1;
                            state_d = req0 ? G0 : G1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (!req1) begin
                        cnt_d   = '0;
                        last_d  = 1'b1;
                        state_d = req0 ? G0 : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1, fifo_full;
    logic [7:0] data0, data1;
    logic       wen_a, ack0_a, ack1_a, gnt0_a, gnt1_a;
    logic       wen_b, ack0_b, ack1_b, gnt0_b, gnt1_b;
    logic [7:0] din_a, din_b;
    int         n_chk = 0, n_pass = 0, n_fail = 0, fill = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(8), .BURST(4)) u_b4 (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .fifo_full(fifo_full), .fifo_wen(wen_a), .fifo_din(din_a),
        .ack0(ack0_a), .ack1(ack1_a), .gnt0(gnt0_a), .gnt1(gnt1_a)
    );

    fifo_wr_arbiter #(.DW(8), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .fifo_full(fifo_full), .fifo_wen(wen_b), .fifo_din(din_b),
        .ack0(ack0_b), .ack1(ack1_b), .gnt0(gnt0_b), .gnt1(gnt1_b)
    );

    // One cycle: check {gnt0,gnt1,ack0,ack1,wen,din} at negedge, then step past posedge.
    task automatic cyc(input string tag, input bit b1, input logic eg0, input logic eg1,
                       input logic ea0, input logic ea1, input logic [7:0] ed);
        logic [12:0] obs, exp;
        @(negedge clk);
        if (b1) obs = {gnt0_b, gnt1_b, ack0_b, ack1_b, wen_b, din_b};
        else    obs = {gnt0_a, gnt1_a, ack0_a, ack1_a, wen_a, din_a};
        exp = {eg0, eg1, ea0, ea1, ea0 | ea1, ed};
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed g0g1a0a1wen=%b din=%h expected g0g1a0a1wen=%b din=%h",
                   tag, obs[12:8], obs[7:0], exp[12:8], exp[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; fifo_full = 1'b0;
        data0 = 8'h00; data1 = 8'h00; fill = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // 1: single requester, burst continues past BURST words
        do_reset();
        cyc("t1 reset", 0, 0, 0, 0, 0, 8'h00);
        req0 = 1'b1; data0 = 8'hA0;
        cyc("t1 idle", 0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 6; k++) begin
            cyc($sformatf("t1 w%0d", k), 0, 1, 0, 1, 0, 8'hA0 + 8'(k));
            data0 = data0 + 8'd1;
        end
        req0 = 1'b0;
        cyc("t1 drop", 0, 1, 0, 0, 0, 8'hA6);
        cyc("t1 back idle", 0, 0, 0, 0, 0, 8'h00);

        // 2: both requesting, bursts of 4 alternate with no idle gap
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h10; data1 = 8'h20;
        cyc("t2 idle", 0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("t2 g0 w%0d", k), 0, 1, 0, 1, 0, 8'h10 + 8'(k));
            data0 = data0 + 8'd1;
        end
        for (int k = 0; k < 4; k++) begin
            cyc($sformatf("t2 g1 w%0d", k), 0, 0, 1, 0, 1, 8'h20 + 8'(k));
            data1 = data1 + 8'd1;
        end
        cyc("t2 g0 again", 0, 1, 0, 1, 0, 8'h14);

        // 3: stall on full mid-burst in G1, then finish the burst
        do_reset();
        req1 = 1'b1; data1 = 8'h30;
        cyc("t3 idle", 0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            cyc($sformatf("t3 w%0d", k), 0, 0, 1, 0, 1, 8'h30 + 8'(k));
            data1 = data1 + 8'd1;
        end
        fifo_full = 1'b1; req0 = 1'b1; data0 = 8'h40;
        for (int k = 0; k < 5; k++) cyc($sformatf("t3 stall%0d", k), 0, 0, 1, 0, 0, 8'h32);
        fifo_full = 1'b0;
        for (int k = 2; k < 4; k++) begin
            cyc($sformatf("t3 w%0d", k), 0, 0, 1, 0, 1, 8'h30 + 8'(k));
            data1 = data1 + 8'd1;
        end
        cyc("t3 pass g0", 0, 1, 0, 1, 0, 8'h40);

        // 4: requester 0 drops early, then a tie goes back to G0
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h48; data1 = 8'h58;
        cyc("t4 idle", 0, 0, 0, 0, 0, 8'h00);
        cyc("t4 g0 w0", 0, 1, 0, 1, 0, 8'h48);
        data0 = 8'h49; req0 = 1'b0;
        cyc("t4 g0 drop", 0, 1, 0, 0, 0, 8'h49);
        cyc("t4 g1 w0", 0, 0, 1, 0, 1, 8'h58);
        data1 = 8'h59; req1 = 1'b0;
        cyc("t4 g1 drop", 0, 0, 1, 0, 0, 8'h59);
        req0 = 1'b1; req1 = 1'b1;
        cyc("t4 tie idle", 0, 0, 0, 0, 0, 8'h00);
        cyc("t4 tie g0", 0, 1, 0, 1, 0, 8'h49);

        // 5: reset mid-burst after last flipped to 0; tie must still go to G0
        do_reset();
        req0 = 1'b1; data0 = 8'h50;
        cyc("t5 idle", 0, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            cyc($sformatf("t5 w%0d", k), 0, 1, 0, 1, 0, 8'h50 + 8'(k));
            data0 = data0 + 8'd1;
        end
        rst = 1'b1; req1 = 1'b1; data1 = 8'h65;
        cyc("t5 in rst", 0, 1, 0, 0, 0, 8'h00);
        rst = 1'b0;
        cyc("t5 after rst", 0, 0, 0, 0, 0, 8'h00);
        cyc("t5 tie g0", 0, 1, 0, 1, 0, 8'h55);

        // 6: BURST=1 alternates every word until the 8-deep FIFO fills
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h60; data1 = 8'h70;
        cyc("t6 idle", 1, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                cyc($sformatf("t6 w%0d", k), 1, 1, 0, 1, 0, 8'h60 + 8'(k / 2));
                data0 = data0 + 8'd1;
            end else begin
                cyc($sformatf("t6 w%0d", k), 1, 0, 1, 0, 1, 8'h70 + 8'(k / 2));
                data1 = data1 + 8'd1;
            end
            fill++;
            fifo_full = (fill >= 8);
        end
        cyc("t6 full0", 1, 1, 0, 0, 0, 8'h64);
        cyc("t6 full1", 1, 1, 0, 0, 0, 8'h64);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
